cnn_frame_sequencer: RTL and testbench
======================================

# cnn_frame_sequencer

Frame-level controller for the single-channel conv→BN→leaky-ReLU→2×2-maxpool streaming pipeline. On a start pulse it holds the pipeline in reset until the frame begins. It then reads one IMG_W×IMG_H frame from a synchronous-read pixel memory and streams it into the pipeline in raster order. Pooled results are collected and tagged with a sequence index, and a done pulse is raised when the expected number of results has arrived or a drain timeout expires. It sits between the frame-buffer memory and the pipeline top.

## Interface
- DATA_W, 8, pixel/result width (signed)
- IMG_W, 8, frame width in pixels
- IMG_H, 8, frame height in pixels
- ADDR_W, 6, memory address width; must satisfy 2^ADDR_W ≥ IMG_W·IMG_H
- EXP_OUT, 9, pooled results expected per frame
- OUT_W, 4, width of result index/counter; must satisfy 2^OUT_W > EXP_OUT
- TIMEOUT, 64, max DRAIN cycles before aborting; 1 ≤ TIMEOUT ≤ 2^16
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  frame request, sampled only in IDLE
- hold  in  1  pause feeding; no memory read is issued in a FEED cycle with hold=1
- busy  out  1  high in FEED and DRAIN
- done  out  1  one-cycle pulse at frame end
- timeout_err  out  1  sticky; set on drain timeout, cleared on accepted start
- ovf_err  out  1  sticky; set on a result beyond EXP_OUT, cleared on accepted start
- mem_rd_en  out  1  memory read strobe
- mem_addr  out  ADDR_W  read address (pixel index, raster order)
- mem_rd_data  in  DATA_W  memory data, valid one cycle after mem_rd_en
- cnn_rst  out  1  pipeline reset (the pipeline's reset is synchronous)
- cnn_in_valid  out  1  pixel valid to pipeline
- cnn_pixel  out  DATA_W  pixel to pipeline
- cnn_out_valid  in  1  pooled result valid from pipeline
- cnn_out_data  in  DATA_W  pooled result
- res_valid  out  1  forwarded result valid
- res_data  out  DATA_W  forwarded result
- res_index  out  OUT_W  result sequence number within frame, 0-based

## Operation
- States: IDLE, FEED, DRAIN, DONE.
- IDLE:
  - start=1 → FEED.
  - On that transition: clear pix_cnt, out_cnt, drain timer, timeout_err and ovf_err.
- FEED:
  - mem_rd_en = !hold (combinational from state and hold).
  - mem_addr = pix_cnt (registered counter); pix_cnt increments on each issued read.
  - Read issued with pix_cnt = IMG_W·IMG_H−1 → DRAIN.
- DRAIN:
  - Drain timer increments every cycle; no reads are issued.
  - out_cnt = EXP_OUT → DONE.
  - Timer reaches TIMEOUT−1 with out_cnt < EXP_OUT → DONE, and timeout_err set.
  - If both conditions hold in the same cycle, the count wins: no error.
- DONE: lasts one cycle → IDLE.
- Pipeline feed:
  - cnn_in_valid is mem_rd_en delayed one cycle (registered).
  - cnn_pixel = mem_rd_data, passed through combinationally.
- cnn_rst is registered: 1 when the next state is IDLE or DONE, 0 when it is FEED or DRAIN. The pipeline is therefore held in reset between frames, and line buffers start clean.
- Results:
  - While in FEED or DRAIN, each cnn_out_valid with out_cnt < EXP_OUT produces res_valid=1 the next cycle, with res_data = cnn_out_data and res_index = out_cnt. out_cnt then increments.
  - cnn_out_valid with out_cnt = EXP_OUT is dropped and sets ovf_err.
  - Results outside FEED/DRAIN are dropped silently.
- start outside IDLE is ignored.
- hold is ignored outside FEED.
- Counters do not wrap within a frame; pix_cnt never exceeds IMG_W·IMG_H−1.

## Timing
- Reset values (asserted asynchronously):
  - state = IDLE.
  - cnn_rst = 1.
  - All other outputs 0, including mem_addr = 0 and res_index = 0.
  - All counters 0.
- Frame start:
  - start sampled 1 at edge E0 → FEED after E0.
  - cnn_rst falls after E0.
  - First read (addr 0) occurs in the cycle after E0 if hold=0.
- Read-to-pipeline latency: a read issued in cycle n gives cnn_in_valid=1 with that pixel in cycle n+1.
- Frame timing with hold never asserted:
  - Reads occupy exactly IMG_W·IMG_H consecutive cycles.
  - DRAIN begins the cycle after the last read; the last cnn_in_valid falls in the first DRAIN cycle.
- Result latency: cnn_out_valid to res_valid is 1 cycle.
- DRAIN exit:
  - DONE follows the edge at which the EXP_OUT-th result is counted.
  - done=1 during DONE; busy=0 in DONE.
- Timeout: DONE is entered after exactly TIMEOUT DRAIN cycles.
- Reset mid-frame:
  - Immediate return to IDLE; cnn_rst=1.
  - No done pulse; flags cleared.
  - The next start begins at addr 0.

## Test plan
- Reset check: assert rst mid-cycle → cnn_rst=1 and busy=done=mem_rd_en=cnn_in_valid=res_valid=0 immediately; both error flags 0.
- Nominal frame (defaults; pipeline model returns 9 results): 64 reads at addresses 0..63 on consecutive cycles → cnn_in_valid mirrors each read 1 cycle later, res_index 0..8, single done pulse, both flags 0.
- Hold toggled every other FEED cycle → exactly 64 reads, addresses strictly increasing by 1, no duplicate or missing cnn_in_valid, DRAIN entered only after addr 63.
- Model returns only 8 results → DONE after 64 DRAIN cycles with timeout_err=1 and res_index 0..7 seen; timeout_err is cleared by the next start.
- Model returns 10 results, all during FEED → 9 forwarded, 10th dropped, ovf_err=1, done after the last read.
- start pulsed during FEED → ignored, no restart. rst asserted at address 30 → return to IDLE, no done pulse; the next start reads from addr 0.

Source files
------------

// File: rtl/cnn_frame_sequencer.sv
// cnn_frame_sequencer
//   Frame-level controller for a single-channel conv/BN/leaky-ReLU/maxpool
//   streaming pipeline. A start request in IDLE releases the pipeline reset,
//   reads one IMG_W x IMG_H frame in raster order from a synchronous-read
//   pixel memory, and streams it into the pipeline. Pooled results are
//   forwarded with a 0-based sequence index. Frame end comes when EXP_OUT
//   results have been counted or the drain timer expires.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   start                frame request (only honoured in IDLE)
//   hold                 suppresses memory reads while feeding
//   busy, done           frame in progress / one-cycle end-of-frame pulse
//   timeout_err, ovf_err sticky error flags, cleared by an accepted start
//   mem_rd_en, mem_addr  memory read strobe and pixel address
//   mem_rd_data          memory data, valid the cycle after mem_rd_en
//   cnn_rst              registered pipeline reset (high between frames)
//   cnn_in_valid         pixel valid to pipeline, cnn_pixel pixel to pipeline
//   cnn_out_valid/_data  pooled result from pipeline
//   res_valid/_data/_index forwarded result and its sequence number
//   dbg_state_o          current FSM state (IDLE=0, FEED=1, DRAIN=2, DONE=3)
//
// Handshake: all valid signals are single-cycle qualifiers with no back
// pressure; a result is taken in any cycle its valid is high.
module cnn_frame_sequencer #(
    parameter int DATA_W  = 8,
    parameter int IMG_W   = 8,
    parameter int IMG_H   = 8,
    parameter int ADDR_W  = 6,
    parameter int EXP_OUT = 9,
    parameter int OUT_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              hold,
    output logic              busy,
    output logic              done,
    output logic              timeout_err,
    output logic              ovf_err,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              cnn_rst,
    output logic              cnn_in_valid,
    output logic [DATA_W-1:0] cnn_pixel,
    input  logic              cnn_out_valid,
    input  logic [DATA_W-1:0] cnn_out_data,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    output logic [OUT_W-1:0]  res_index,
    output logic [1:0]        dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int TMR_W = 17;
    localparam int NPIX  = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NPIX - 1);
    localparam logic [OUT_W-1:0]  EXP_CNT  = OUT_W'(EXP_OUT);
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pix_cnt_q;
    logic [OUT_W-1:0]    out_cnt_q;
    logic [TMR_W-1:0]    timer_q;
    logic                timeout_err_q, ovf_err_q;
    logic                cnn_rst_q, cnn_in_valid_q;
    logic                res_valid_q;
    logic [DATA_W-1:0]   res_data_q;
    logic [OUT_W-1:0]    res_index_q;
    logic                start_acc;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_FEED;
            S_FEED:  if (!hold && pix_cnt_q == LAST_PIX) state_d = S_DRAIN;
            // A full result count takes priority over a simultaneous timeout.
            S_DRAIN: if (out_cnt_q == EXP_CNT || timer_q == TMR_LAST) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy        = (state_q == S_FEED) || (state_q == S_DRAIN);
        done        = (state_q == S_DONE);
        mem_rd_en   = (state_q == S_FEED) && !hold;
        dbg_state_o = state_q;
    end

    assign start_acc = (state_q == S_IDLE) && start;

    // Datapath: counters, flags, pipeline feed and result forwarding
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_cnt_q      <= '0;
            out_cnt_q      <= '0;
            timer_q        <= '0;
            timeout_err_q  <= 1'b0;
            ovf_err_q      <= 1'b0;
            cnn_rst_q      <= 1'b1;
            cnn_in_valid_q <= 1'b0;
            res_valid_q    <= 1'b0;
            res_data_q     <= '0;
            res_index_q    <= '0;
        end else begin
            // Pipeline reset tracks the state being entered so it releases
            // together with the FEED entry and reasserts with DONE.
            cnn_rst_q      <= (state_d == S_IDLE) || (state_d == S_DONE);
            cnn_in_valid_q <= mem_rd_en;
            res_valid_q    <= 1'b0;

            if (start_acc) begin
                pix_cnt_q     <= '0;
                out_cnt_q     <= '0;
                timer_q       <= '0;
                timeout_err_q <= 1'b0;
                ovf_err_q     <= 1'b0;
            end

            // The last read leaves the address parked at the final pixel.
            if (mem_rd_en && pix_cnt_q != LAST_PIX)
                pix_cnt_q <= pix_cnt_q + 1'b1;

            if (state_q == S_DRAIN) begin
                timer_q <= timer_q + 1'b1;
                if (timer_q == TMR_LAST && out_cnt_q != EXP_CNT)
                    timeout_err_q <= 1'b1;
            end

            if (busy && cnn_out_valid) begin
                if (out_cnt_q != EXP_CNT) begin
                    res_valid_q <= 1'b1;
                    res_data_q  <= cnn_out_data;
                    res_index_q <= out_cnt_q;
                    out_cnt_q   <= out_cnt_q + 1'b1;
                end else begin
                    ovf_err_q <= 1'b1;
                end
            end
        end
    end

    assign mem_addr     = pix_cnt_q;
    assign timeout_err  = timeout_err_q;
    assign ovf_err      = ovf_err_q;
    assign cnn_rst      = cnn_rst_q;
    assign cnn_in_valid = cnn_in_valid_q;
    assign cnn_pixel    = mem_rd_data;
    assign res_valid    = res_valid_q;
    assign res_data     = res_data_q;
    assign res_index    = res_index_q;

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// Bench for cnn_frame_sequencer: a memory model, a behavioural pipeline
// model emitting results on a per-frame plan, a monitor gathering what the
// DUT did, and directed frames checked against expectations from the rules.
module tb_cnn_frame_sequencer;
  localparam int DATA_W  = 8;
  localparam int IMG_W   = 8;
  localparam int IMG_H   = 8;
  localparam int ADDR_W  = 6;
  localparam int EXP_OUT = 9;
  localparam int OUT_W   = 4;
  localparam int TIMEOUT = 64;
  localparam int NPIX    = IMG_W * IMG_H;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic hold = 1'b0;
  always #5 clk = ~clk;

  logic              busy, done, timeout_err, ovf_err, mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              cnn_rst, cnn_in_valid;
  logic [DATA_W-1:0] cnn_pixel;
  logic              cnn_out_valid = 1'b0;
  logic [DATA_W-1:0] cnn_out_data = '0;
  logic              res_valid;
  logic [DATA_W-1:0] res_data;
  logic [OUT_W-1:0]  res_index;
  logic [1:0]        dbg_state;

  cnn_frame_sequencer #(
    .DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W),
    .EXP_OUT(EXP_OUT), .OUT_W(OUT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .hold(hold),
    .busy(busy), .done(done), .timeout_err(timeout_err), .ovf_err(ovf_err),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .cnn_rst(cnn_rst), .cnn_in_valid(cnn_in_valid), .cnn_pixel(cnn_pixel),
    .cnn_out_valid(cnn_out_valid), .cnn_out_data(cnn_out_data),
    .res_valid(res_valid), .res_data(res_data), .res_index(res_index),
    .dbg_state_o(dbg_state)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // synchronous-read memory
  logic [DATA_W-1:0] mem [NPIX];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

  // pipeline model: emits plan_n results at frame cycles base + step*k
  int plan_n = 0, plan_base = 0, plan_step = 1;
  int emitted = 0, frame_cyc = 0;
  logic [OUT_W+DATA_W-1:0] exp_q[$];
  logic [OUT_W+DATA_W-1:0] got_q[$];
  always @(negedge clk) begin
    cnn_out_valid = 1'b0;
    if (busy) begin
      frame_cyc++;
      if (emitted < plan_n && frame_cyc == plan_base + plan_step * emitted) begin
        cnn_out_valid = 1'b1;
        cnn_out_data  = DATA_W'($urandom);
        if (emitted < EXP_OUT) exp_q.push_back({OUT_W'(emitted), cnn_out_data});
        emitted++;
      end
    end else begin
      frame_cyc = 0;
      emitted   = 0;
    end
  end

  // monitor: cumulative counters, per-frame address tracking
  int rd_total = 0, rd_in_frame = 0, rd_addr_bad = 0, feed_bad = 0;
  int done_total = 0, done_bad = 0, done_cyc = 0, first_rd_cyc = 0, last_rd_cyc = 0;
  logic prev_rd = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;
  always @(negedge clk) begin
    if (cnn_in_valid) begin
      if (!prev_rd || cnn_pixel !== mem[prev_addr]) feed_bad++;
    end else if (prev_rd) begin
      feed_bad++;
    end
    if (mem_rd_en && hold) feed_bad++;
    prev_rd   = mem_rd_en;
    prev_addr = mem_addr;
    if (!busy) rd_in_frame = 0;
    if (mem_rd_en) begin
      if (mem_addr !== ADDR_W'(rd_in_frame)) rd_addr_bad++;
      if (rd_in_frame == 0) first_rd_cyc = cyc;
      last_rd_cyc = cyc;
      rd_in_frame++;
      rd_total++;
    end
    if (res_valid) got_q.push_back({res_index, res_data});
    if (done) begin
      done_total++;
      done_cyc = cyc;
      if (busy || !cnn_rst) done_bad++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input string tag, input int n, input int base, input int stp,
                           input bit hold_mode, input bit start_mid);
    int start_cyc, budget, rd0, fb0, ab0, d0, db0, e0, g0, ne, ng;
    for (int i = 0; i < NPIX; i++) mem[i] = DATA_W'($urandom);
    plan_n = n; plan_base = base; plan_step = stp;
    rd0 = rd_total; fb0 = feed_bad; ab0 = rd_addr_bad; d0 = done_total; db0 = done_bad;
    e0 = exp_q.size(); g0 = got_q.size();
    chk($sformatf("%s.idle_cnn_rst", tag), cnn_rst, 1);
    start = 1'b1;
    start_cyc = cyc;
    step();
    start = 1'b0;
    chk($sformatf("%s.busy_after_start", tag), busy, 1);
    chk($sformatf("%s.cnn_rst_released", tag), cnn_rst, 0);
    chk($sformatf("%s.timeout_cleared", tag), timeout_err, 0);
    chk($sformatf("%s.ovf_cleared", tag), ovf_err, 0);
    budget = 0;
    while (done_total == d0 && budget < 600) begin
      if (hold_mode) hold = ~hold;
      start = (start_mid && budget == 10);
      step();
      budget++;
    end
    hold = 1'b0;
    start = 1'b0;
    chk($sformatf("%s.done_seen", tag), done_total != d0, 1);
    repeat (4) step();
    chk($sformatf("%s.done_pulses", tag), done_total - d0, 1);
    chk($sformatf("%s.done_while_busy", tag), done_bad - db0, 0);
    chk($sformatf("%s.reads", tag), rd_total - rd0, NPIX);
    chk($sformatf("%s.read_addr_order", tag), rd_addr_bad - ab0, 0);
    chk($sformatf("%s.feed_errors", tag), feed_bad - fb0, 0);
    chk($sformatf("%s.done_after_last_read", tag), done_cyc > last_rd_cyc, 1);
    chk($sformatf("%s.idle_busy", tag), busy, 0);
    if (!hold_mode) begin
      chk($sformatf("%s.first_read_cycle", tag), first_rd_cyc - start_cyc, 1);
      chk($sformatf("%s.read_span", tag), last_rd_cyc - first_rd_cyc, NPIX - 1);
    end
    ne = exp_q.size() - e0;
    ng = got_q.size() - g0;
    chk($sformatf("%s.result_count", tag), ng, ne);
    for (int i = 0; i < ne && i < ng; i++)
      chk($sformatf("%s.result%0d", tag, i), got_q[g0 + i], exp_q[e0 + i]);
  endtask

  initial begin
    int b, d0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.cnn_rst", cnn_rst, 1);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.mem_rd_en", mem_rd_en, 0);
    chk("rst.mem_addr", mem_addr, 0);
    chk("rst.cnn_in_valid", cnn_in_valid, 0);
    chk("rst.res_valid", res_valid, 0);
    chk("rst.res_index", res_index, 0);
    chk("rst.timeout_err", timeout_err, 0);
    chk("rst.ovf_err", ovf_err, 0);
    rst = 1'b0;
    step();

    run_frame("nominal", 9, 20, 6, 1'b0, 1'b0);
    chk("nominal.timeout_err", timeout_err, 0);
    chk("nominal.ovf_err", ovf_err, 0);

    run_frame("hold", 9, 20, 6, 1'b1, 1'b0);
    chk("hold.timeout_err", timeout_err, 0);
    chk("hold.ovf_err", ovf_err, 0);

    run_frame("timeout", 8, 20, 6, 1'b0, 1'b0);
    chk("timeout.timeout_err", timeout_err, 1);
    chk("timeout.ovf_err", ovf_err, 0);
    chk("timeout.drain_cycles", done_cyc - last_rd_cyc, TIMEOUT + 1);

    run_frame("ovf", 10, 5, 3, 1'b0, 1'b0);
    chk("ovf.ovf_err", ovf_err, 1);
    chk("ovf.timeout_err", timeout_err, 0);

    // asynchronous reset while idle with a sticky flag set
    #3 rst = 1'b1;
    #1;
    chk("idle_rst.ovf_err", ovf_err, 0);
    chk("idle_rst.cnn_rst", cnn_rst, 1);
    chk("idle_rst.busy", busy, 0);
    step();
    rst = 1'b0;
    step();

    run_frame("start_mid", 9, 20, 6, 1'b0, 1'b1);
    chk("start_mid.ovf_err", ovf_err, 0);

    // reset in the middle of a frame, at address 30
    plan_n = 0;
    d0 = done_total;
    start = 1'b1;
    step();
    start = 1'b0;
    b = 0;
    while (!(mem_rd_en && mem_addr == 30) && b < 200) begin
      step();
      b++;
    end
    chk("midrst.reached_addr30", mem_rd_en && mem_addr == 30, 1);
    #3 rst = 1'b1;
    #1;
    chk("midrst.busy", busy, 0);
    chk("midrst.cnn_rst", cnn_rst, 1);
    chk("midrst.mem_rd_en", mem_rd_en, 0);
    chk("midrst.mem_addr", mem_addr, 0);
    chk("midrst.cnn_in_valid", cnn_in_valid, 0);
    chk("midrst.done", done, 0);
    step();
    rst = 1'b0;
    repeat (10) step();
    chk("midrst.no_done", done_total - d0, 0);
    chk("midrst.idle", busy, 0);

    run_frame("after_rst", 9, 20, 6, 1'b0, 1'b0);
    chk("after_rst.timeout_err", timeout_err, 0);
    chk("after_rst.ovf_err", ovf_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
